mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath mux/enable, including the 2-bit ALUOp consumed by the ALU control decoder.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
MEM_WAIT, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
op  input  6  opcode field IR[31:26] from instruction register
mem_ready  input  1  memory completes the current read/write this cycle
pc_write  output  1  unconditional PC load
branch_eq  output  1  PC load if ALU zero
branch_ne  output  1  PC load if ALU not zero
iord  output  1  0 = PC addresses memory, 1 = ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load
mem_to_reg  output  1  writeback source 1 = MDR, 0 = ALUOut
reg_dst  output  1  1 = rd, 0 = rt
reg_write  output  1  register file write
alu_src_a  output  1  0 = PC, 1 = rs
alu_src_b  output  2  00 = rt, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
alu_op  output  2  00 add, 01 subtract, 10 use funct
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state  output  4  current state (debug)
illegal_op  output  1  sticky: unsupported opcode decoded
instr_cnt  output  CNT_W  retired instruction count

Behaviour:
- rst asserted (async): state=RESET(0), op_q=0, illegal_op=0, instr_cnt=0. All control outputs are 0 in RESET.
- RESET exits to FETCH on the first clk edge with rst low.
- Control outputs are Moore decodes of state, except the fetch/memory enables, which are gated by mem_ready. Any output not listed for a state is 0.
- State encoding and outputs:
  - FETCH(1): mem_read=1, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Stay in FETCH while !mem_ready, else go to DECODE.
  - DECODE(2): alu_src_b=11, alu_op=00; latch op into op_q.
    - DECODE next state by op: 100011 lw or 101011 sw -> MEMADR; 000000 -> EXEC; 000100 beq or 000101 bne -> BRANCH; 001000 addi -> ADDIEX; 000010 j -> JUMP.
    - Any other opcode -> FETCH, set illegal_op=1; illegal_op stays set until rst; instr_cnt not incremented.
  - MEMADR(3): alu_src_a=1, alu_src_b=10, alu_op=00. Next: op_q=lw -> MEMRD, else MEMWR.
  - MEMRD(4): mem_read=1, iord=1. Hold until mem_ready, then -> MEMWB.
  - MEMWB(5): reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
  - MEMWR(6): mem_write=1, iord=1. Hold until mem_ready, then -> FETCH.
  - EXEC(7): alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
  - ALUWB(8): reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
  - BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01. branch_eq=1 if op_q=beq; branch_ne=1 if op_q=bne. -> FETCH.
  - ADDIEX(10): alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
  - ADDIWB(11): reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
  - JUMP(12): pc_write=1, pc_source=10 -> FETCH.
  - Codes 13-15: unreachable. If entered, go to FETCH with all outputs 0.
- Cycle counts with mem_ready=1: lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3. Each stall cycle adds 1.
- Retire: instr_cnt increments by 1 on the edge leaving MEMWB, ALUWB, ADDIWB, BRANCH or JUMP, and on the edge leaving MEMWR with mem_ready=1. It wraps modulo 2^CNT_W.
- mem_read/mem_write stay asserted through stall cycles. mem_write is never asserted in the same cycle as mem_read.
- rst mid-instruction: immediate return to RESET; no partial writes, since all strobes drop asynchronously.
- MEM_WAIT=0: no state ever stalls.

Test Plan:
- Reset then R-type: rst 1->0, op=000000, mem_ready=1 -> states 0,1,2,7,8,1; alu_op=10 in EXEC; reg_write & reg_dst=1 in ALUWB; instr_cnt=1.
- lw with 2 stall cycles in MEMRD: op=100011, mem_ready low 2 cycles in state 4 -> mem_read=1, iord=1 held 3 cycles; MEMWB has mem_to_reg=1; total 7 cycles; instr_cnt+1.
- beq vs bne: op=000100 -> BRANCH with branch_eq=1, branch_ne=0, alu_op=01, pc_source=01. Repeat with op=000101 -> branch_ne=1 only. 3 cycles each.
- addi, j, sw sequence with mem_ready=1 -> 4+3+4=11 cycles; instr_cnt=3; j has pc_source=10 and pc_write=1; sw has mem_write=1 for 1 cycle.
- Illegal op=111111 -> DECODE->FETCH; illegal_op=1 and stays 1 across later legal instructions; instr_cnt unchanged.
- Async reset asserted mid-MEMWR with mem_ready=0 -> mem_write drops before next clk edge, state=0, instr_cnt=0, illegal_op=0. CNT_W=4 wrap: 16 retires -> instr_cnt=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Main control FSM for the multicycle MIPS datapath. Each instruction is
//   walked through fetch, decode, execute, memory and writeback states; the
//   datapath controls are Moore decodes of the current state, with the
//   fetch/memory enables qualified by the memory ready handshake.
//
// Parameters
//   MEM_WAIT  1 = honour mem_ready, 0 = memory is always ready
//   CNT_W     width of the retired-instruction counter
//
// Ports
//   clk, rst          clock (rising edge) and async active-high reset
//   op                opcode IR[31:26]
//   mem_ready         memory completes the current access this cycle
//   pc_write, branch_eq, branch_ne, pc_source   PC update controls
//   iord, mem_read, mem_write, ir_write          memory / IR controls
//   mem_to_reg, reg_dst, reg_write               register file controls
//   alu_src_a, alu_src_b, alu_op                 ALU operand / op controls
//   state             current FSM state (debug)
//   illegal_op        sticky flag: unsupported opcode decoded
//   instr_cnt         retired instruction count (wraps)
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter bit MEM_WAIT = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t           state_r;
  state_t           state_s;
  logic [5:0]       op_q_r;
  logic             illegal_op_r;
  logic [CNT_W-1:0] instr_cnt_r;
  logic             rdy_s;
  logic             illegal_s;
  logic             retire_s;

  // With MEM_WAIT=0 the handshake is ignored so no state ever stalls.
  assign rdy_s      = MEM_WAIT ? mem_ready : 1'b1;
  assign state      = state_r;
  assign illegal_op = illegal_op_r;
  assign instr_cnt  = instr_cnt_r;

  // Next-state, retire/illegal events and Moore control decode.
  always_comb begin
    state_s    = S_FETCH;
    illegal_s  = 1'b0;
    retire_s   = 1'b0;
    pc_write   = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    case (state_r)
      S_RESET: state_s = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy_s;
        pc_write  = rdy_s;
        if (rdy_s) state_s = S_DECODE;
        else       state_s = S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW:   state_s = S_MEMADR;
          OP_RTYPE:       state_s = S_EXEC;
          OP_BEQ, OP_BNE: state_s = S_BRANCH;
          OP_ADDI:        state_s = S_ADDIEX;
          OP_J:           state_s = S_JUMP;
          default: begin
            state_s   = S_FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (op_q_r == OP_LW) state_s = S_MEMRD;
        else                 state_s = S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (rdy_s) state_s = S_MEMWB;
        else       state_s = S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_s   = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (rdy_s) begin
          state_s  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          state_s  = S_MEMWR;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_s   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire_s  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        branch_eq = (op_q_r == OP_BEQ);
        branch_ne = (op_q_r == OP_BNE);
        retire_s  = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_s   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire_s  = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire_s  = 1'b1;
      end
      // Codes 13-15 are unreachable; recover to FETCH with all controls low.
      default: state_s = S_FETCH;
    endcase
  end

  // State, latched opcode, sticky illegal flag and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_RESET;
      op_q_r       <= 6'b000000;
      illegal_op_r <= 1'b0;
      instr_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_r == S_DECODE) op_q_r <= op;
      if (illegal_s) illegal_op_r <= 1'b1;
      if (retire_s) instr_cnt_r <= instr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    op;
  logic          mem_ready;
  logic          pc_write, branch_eq, branch_ne, iord, mem_read, mem_write;
  logic          ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [3:0]    state;
  logic          illegal_op;
  logic [CW-1:0] instr_cnt;

  mips_multicycle_ctrl #(.MEM_WAIT(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .state(state),
    .illegal_op(illegal_op), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] RT = 6'b000000, J = 6'b000010, BEQ = 6'b000100,
                         BNE = 6'b000101, ADDI = 6'b001000, LW = 6'b100011,
                         SW = 6'b101011, BAD = 6'b111111;

  typedef struct {
    logic [3:0]    st;
    logic [16:0]   ctrl;
    logic [CW-1:0] cnt;
    logic          ill;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  int            cyc_n = 0;
  logic [5:0]    opq_m = 6'b000000;
  logic [CW-1:0] cnt_m = '0;
  logic          ill_m = 1'b0;
  logic [16:0]   ctrl_obs;

  assign ctrl_obs = {pc_write, branch_eq, branch_ne, iord, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_source};

  // Expected control vector for a state, written straight from the state table.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic [5:0] opq,
                                           input logic rdy);
    logic pcw, beq, bne, io, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb2, ao, ps;
    {pcw, beq, bne, io, mr, mw, irw, m2r, rd, rw, sa} = 11'b0;
    sb2 = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      4'd1:  begin mr = 1'b1; sb2 = 2'b01; irw = rdy; pcw = rdy; end
      4'd2:  sb2 = 2'b11;
      4'd3:  begin sa = 1'b1; sb2 = 2'b10; end
      4'd4:  begin mr = 1'b1; io = 1'b1; end
      4'd5:  begin rw = 1'b1; m2r = 1'b1; end
      4'd6:  begin mw = 1'b1; io = 1'b1; end
      4'd7:  begin sa = 1'b1; ao = 2'b10; end
      4'd8:  begin rw = 1'b1; rd = 1'b1; end
      4'd9:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01;
                   beq = (opq == BEQ); bne = (opq == BNE); end
      4'd10: begin sa = 1'b1; sb2 = 2'b10; end
      4'd11: rw = 1'b1;
      4'd12: begin pcw = 1'b1; ps = 2'b10; end
      default: ;
    endcase
    return {pcw, beq, bne, io, mr, mw, irw, m2r, rd, rw, sa, sb2, ao, ps};
  endfunction

  function automatic logic legal(input logic [5:0] o);
    return (o == RT) || (o == J) || (o == BEQ) || (o == BNE) ||
           (o == ADDI) || (o == LW) || (o == SW);
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  // Drive inputs and push the expected result for this cycle.
  task automatic drive_push(input logic [3:0] st, input logic [5:0] o, input logic rdy);
    exp_t e;
    op = o;
    mem_ready = rdy;
    e.st = st;
    e.ctrl = exp_ctrl(st, opq_m, rdy);
    e.cnt = cnt_m;
    e.ill = ill_m;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty cycle=%0d observed=0 expected=1", cyc_n);
    end else begin
      e = sb.pop_front();
      cmp("state", 32'(state), 32'(e.st));
      cmp("ctrl", 32'(ctrl_obs), 32'(e.ctrl));
      cmp("instr_cnt", 32'(instr_cnt), 32'(e.cnt));
      cmp("illegal_op", 32'(illegal_op), 32'(e.ill));
    end
  endtask

  // One clock cycle in the given expected state; model updates for the edge.
  task automatic cyc(input logic [3:0] st, input logic [5:0] o, input logic rdy);
    drive_push(st, o, rdy);
    check_pop();
    if (!rst) begin
      if (st == 4'd2) begin
        opq_m = o;
        if (!legal(o)) ill_m = 1'b1;
      end
      if (st == 4'd5 || st == 4'd8 || st == 4'd9 || st == 4'd11 || st == 4'd12 ||
          (st == 4'd6 && rdy))
        cnt_m = cnt_m + 1'b1;
    end
    cyc_n++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; op = 6'b0; mem_ready = 1'b0;
    @(negedge clk);
    cyc(4'd0, RT, 1'b1);                 // held in reset
    rst = 1'b0;
    // reset then R-type: 0,1,2,7,8
    cyc(4'd0, RT, 1'b1);
    cyc(4'd1, RT, 1'b1); cyc(4'd2, RT, 1'b1); cyc(4'd7, RT, 1'b1); cyc(4'd8, RT, 1'b1);
    // lw with two stall cycles in MEMRD
    cyc(4'd1, LW, 1'b1); cyc(4'd2, LW, 1'b1); cyc(4'd3, LW, 1'b1);
    cyc(4'd4, LW, 1'b0); cyc(4'd4, LW, 1'b0); cyc(4'd4, LW, 1'b1); cyc(4'd5, LW, 1'b1);
    // beq then bne
    cyc(4'd1, BEQ, 1'b1); cyc(4'd2, BEQ, 1'b1); cyc(4'd9, BEQ, 1'b1);
    cyc(4'd1, BNE, 1'b1); cyc(4'd2, BNE, 1'b1); cyc(4'd9, BNE, 1'b1);
    // addi, j, sw
    cyc(4'd1, ADDI, 1'b1); cyc(4'd2, ADDI, 1'b1); cyc(4'd10, ADDI, 1'b1); cyc(4'd11, ADDI, 1'b1);
    cyc(4'd1, J, 1'b1); cyc(4'd2, J, 1'b1); cyc(4'd12, J, 1'b1);
    cyc(4'd1, SW, 1'b1); cyc(4'd2, SW, 1'b1); cyc(4'd3, SW, 1'b1); cyc(4'd6, SW, 1'b1);
    // fetch stall, illegal opcode, then a legal instruction keeps illegal_op set
    cyc(4'd1, BAD, 1'b0); cyc(4'd1, BAD, 1'b1); cyc(4'd2, BAD, 1'b1);
    cyc(4'd1, RT, 1'b1); cyc(4'd2, RT, 1'b1); cyc(4'd7, RT, 1'b1); cyc(4'd8, RT, 1'b1);
    // sw stalled in MEMWR, then async reset before the next edge
    cyc(4'd1, SW, 1'b1); cyc(4'd2, SW, 1'b1); cyc(4'd3, SW, 1'b1); cyc(4'd6, SW, 1'b0);
    drive_push(4'd6, SW, 1'b0);
    check_pop();
    rst = 1'b1;
    cnt_m = '0; ill_m = 1'b0; opq_m = 6'b0;
    drive_push(4'd0, SW, 1'b0);
    check_pop();
    @(negedge clk);
    rst = 1'b0;
    cyc(4'd0, J, 1'b1);
    // 16 retires wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) begin
      cyc(4'd1, J, 1'b1); cyc(4'd2, J, 1'b1); cyc(4'd12, J, 1'b1);
    end
    cyc(4'd1, J, 1'b0);
    cmp("wrap_cnt", 32'(instr_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
